fp_div: RTL and testbench

//   Sequential signed fixed-point divider y = a / b (Q(WIDTH-FRACTION).FRACTION).
//   It is the inverse operation to fp_mul and shares the same number format and

---
 rtl/fp_div.sv | 141 ++++++++++++++
 tb/tb_fp_div.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// Sequential signed fixed-point divider y = a / b in Q(WIDTH-FRACTION).FRACTION.
// Restoring sign-magnitude division, one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides. Results saturate
// to FP_MAX/FP_MIN; a zero divisor yields a saturated result flagged div_zero.
module fp_div #(
    parameter int WIDTH    = 32,
    parameter int FRACTION = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y,
    output logic                    sat,
    output logic                    div_zero
);

    localparam int ITER  = WIDTH + FRACTION;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [WIDTH-1:0] FP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] FP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;

    // Dividend shifts out of the top while quotient bits shift in at the bottom,
    // so after ITER steps this register holds the quotient magnitude.
    logic [ITER-1:0]      quo;
    logic [WIDTH:0]       dvs;
    logic [WIDTH:0]       rem;
    logic                 neg;

    logic [WIDTH+1:0]     rem_sh;
    logic [WIDTH:0]       rem_sub;
    logic [WIDTH:0]       rem_nxt;
    logic                 q_bit;
    logic [WIDTH:0]       fix_res;

    // Magnitude in WIDTH+1 bits so that |FP_MIN| = 2^(WIDTH-1) is exact.
    function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? -ext : ext;
    endfunction

    // Apply sign and saturation to the truncated quotient magnitude; returns {sat, y}.
    function automatic logic [WIDTH:0] sat_fix(input logic [ITER-1:0] q, input logic q_neg);
        logic [ITER-1:0] lim_pos;
        logic [ITER-1:0] lim_neg;
        lim_pos = ITER'(FP_MAX);
        lim_neg = ITER'(FP_MIN);
        if (!q_neg) begin
            if (q > lim_pos) return {1'b1, FP_MAX};
            return {1'b0, q[WIDTH-1:0]};
        end
        if (q > lim_neg) return {1'b1, FP_MIN};
        return {1'b0, -q[WIDTH-1:0]};
    endfunction

    // Operands are accepted only while idle.
    always_comb begin
        in_ready = (state == IDLE);
    end

    // One restoring step: shift in the next dividend bit and trial-subtract |b|.
    always_comb begin
        rem_sh  = {rem, quo[ITER-1]};
        rem_sub = rem_sh[WIDTH:0] - dvs;
        q_bit   = (rem_sh >= {1'b0, dvs});
        rem_nxt = q_bit ? rem_sub : rem_sh[WIDTH:0];
        fix_res = sat_fix(quo, neg);
    end

    // Datapath: latch magnitudes on accept, then iterate while busy.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            quo <= ITER'(mag(a)) << FRACTION;
            dvs <= mag(b);
            rem <= '0;
            neg <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (state == BUSY) begin
            rem <= rem_nxt;
            quo <= {quo[ITER-2:0], q_bit};
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            sat       <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (b == '0) begin
                            // 0/0 has a clear sign bit and therefore lands on FP_MAX.
                            y         <= a[WIDTH-1] ? FP_MIN : FP_MAX;
                            sat       <= 1'b1;
                            div_zero  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt   <= CNT_W'(ITER - 1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    {sat, y}  <= fix_res;
                    div_zero  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// Directed testbench for fp_div (WIDTH=32, FRACTION=16).
module tb_fp_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        sat;
    logic        div_zero;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fp_div #(.WIDTH(32), .FRACTION(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sat       (sat),
        .div_zero  (div_zero)
    );

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
        longint d;
        n_chk++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    endtask

    task automatic start_div(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ey, input logic es, input logic edz);
        int lat;
        start_div(av, bv);
        wait_out(lat);
        chk({tag, "_lat"}, lat, (bv == 0) ? 1 : 50);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_sat"}, sat, es);
        chk({tag, "_dz"}, div_zero, edz);
        take();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          ai;
        int          bi;
        real         r;
        longint      e;
        logic        es;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_sat", sat, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic, negative and truncating divides
        run("3/2",        32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 0, 0);
        run("-3/0.5",     32'hFFFD_0000, 32'h0000_8000, 32'hFFFA_0000, 0, 0);
        run("1/3",        32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 0, 0);
        run("-1/3",       32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 0, 0);
        run("max/max",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0001_0000, 0, 0);
        run("negzero",    32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 0, 0);

        // Saturation boundaries
        run("32767/0.5",  32'h7FFF_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1, 0);
        run("min/-1",     32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1, 0);
        run("min/1",      32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 0, 0);

        // Divide by zero
        run("5/0",        32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1, 1);
        run("-5/0",       32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1, 1);
        run("0/0",        32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1, 1);

        // Result held while the consumer stalls; new operands ignored meanwhile
        start_div(32'h0007_0000, 32'h0002_0000);
        wait_out(lat);
        chk("hold_lat", lat, 50);
        for (int i = 0; i < 10; i++) begin
            chk("hold_y", y, 32'h0003_8000);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            a = 32'h0001_0000;
            b = 32'h0000_0000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        take();
        chk("hs_in_ready", in_ready, 1);
        chk("hs_out_valid", out_valid, 0);
        chk("hs_y_held", y, 32'h0003_8000);
        chk("hs_dz_held", div_zero, 0);

        // Random operands against a real-valued model
        for (int k = 0; k < 20; k++) begin
            ai = int'($urandom) >>> $urandom_range(0, 24);
            bi = int'($urandom) >>> $urandom_range(0, 24);
            if (bi == 0) bi = 1;
            r = real'(ai) * 65536.0 / real'(bi);
            if (r >= 2147483648.0) begin
                e = 64'sd2147483647;
                es = 1'b1;
            end else if (r <= -2147483649.0) begin
                e = -64'sd2147483648;
                es = 1'b0;
                es = 1'b1;
            end else begin
                e = longint'($rtoi(r));
                es = 1'b0;
            end
            start_div(ai, bi);
            wait_out(lat);
            chk("rnd_lat", lat, 50);
            chk("rnd_y", longint'($signed(y)), e, 1);
            chk("rnd_sat", sat, es);
            take();
        end

        // Asynchronous reset in the middle of a divide
        start_div(32'h7FFF_0000, 32'h0000_0100);
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_y", y, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        run("6/3",        32'h0006_0000, 32'h0003_0000, 32'h0002_0000, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
